// File: rtl/scu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scu_pkg
//  Description : Shared definitions for the queued scalar compute unit:
//                FSM state encoding and default geometry constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package scu_pkg;

    localparam int SCU_MULTIPLIERS_DEF = 18;  // multipliers consumed per compute cycle
    localparam int MULT_WIDTH_DEF      = 32;  // width of mult-count / cycle fields

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scu_state_t;

endpackage
`default_nettype wire

// File: rtl/scu_job_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : scu_job_fifo
//  Description : Synchronous job FIFO. Read data is the current head entry
//                (show-ahead), so a pop consumes what dout presents.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst_n   clock, asynchronous active-low reset
//    clr          synchronous clear (empties the queue, wins over push/pop)
//    push, din    write request and data (ignored when full)
//    pop, dout    read request and head data (ignored when empty)
//    count        entries currently held
//    full, empty  occupancy flags
// ============================================================================
module scu_job_fifo #(
    parameter int DEPTH = 4,    // power of two, >= 2
    parameter int WIDTH = 36
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full && !clr;
    assign pop_ok  = pop && !empty && !clr;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scu_queued.sv
`default_nettype none
// ============================================================================
//  Module      : scu_queued
//  Description : Queued scalar compute unit. Jobs (tag, multiplication count)
//                enter a FIFO; each is serviced in order for
//                ceil(mults / SCU_MULTIPLIERS) cycles, then its tag and cycle
//                count are presented on a valid/ready result port.
//  Revision    : 1.0 - initial release
//
//  Build option: define SCU_QUEUED_PERF_EN to add the performance counters
//                perf_busy_cycles and perf_jobs_done.
//
//  Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    flush                 synchronous abort of queue, current job and result
//    job_valid/job_ready   job handshake; job_mults, job_tag job payload
//    res_valid/res_ready   result handshake; res_tag, res_cycles payload
//    busy                  FSM not IDLE
//    fifo_count            queued jobs, excluding the one in service
//    perf_busy_cycles      (option) saturating count of RUN cycles
//    perf_jobs_done        (option) wrapping count of result handshakes
// ============================================================================
module scu_queued
    import scu_pkg::*;
#(
    parameter int SCU_MULTIPLIERS = SCU_MULTIPLIERS_DEF,
    parameter int MULT_WIDTH      = MULT_WIDTH_DEF,
    parameter int FIFO_DEPTH      = 4,
    parameter int TAG_WIDTH       = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [MULT_WIDTH-1:0]           job_mults,
    input  logic [TAG_WIDTH-1:0]            job_tag,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [TAG_WIDTH-1:0]            res_tag,
    output logic [MULT_WIDTH-1:0]           res_cycles,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef SCU_QUEUED_PERF_EN
    ,
    output logic [31:0]                     perf_busy_cycles,
    output logic [15:0]                     perf_jobs_done
`endif
);

    localparam int DW = TAG_WIDTH + MULT_WIDTH;

    scu_state_t            state;
    logic [MULT_WIDTH-1:0] remaining;
    logic [DW-1:0]         head;
    logic [TAG_WIDTH-1:0]  head_tag;
    logic [MULT_WIDTH-1:0] head_mults;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic [MULT_WIDTH:0]   mults_ext;
    logic [MULT_WIDTH:0]   cycles_ext;
    logic [MULT_WIDTH-1:0] cycles;
    logic                  res_fire;

    // No pop bypass: a full queue refuses a job even while one is leaving.
    assign job_ready = !fifo_full && !flush;
    assign pop       = (state == IDLE) && !fifo_empty && !flush;
    assign busy      = (state != IDLE);
    assign res_fire  = (state == DONE) && res_valid && res_ready && !flush;

    assign head_tag   = head[DW-1:MULT_WIDTH];
    assign head_mults = head[MULT_WIDTH-1:0];

    // Ceiling division in one extra bit so an all-ones count cannot wrap.
    // The quotient always fits MULT_WIDTH bits; the top-bit test only
    // saturates defensively.
    assign mults_ext  = {1'b0, head_mults} + (MULT_WIDTH+1)'(SCU_MULTIPLIERS - 1);
    assign cycles_ext = mults_ext / (MULT_WIDTH+1)'(SCU_MULTIPLIERS);
    assign cycles     = cycles_ext[MULT_WIDTH] ? '1 : cycles_ext[MULT_WIDTH-1:0];

    scu_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (job_valid && job_ready),
        .din   ({job_tag, job_mults}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Result fields latch at pop; res_valid is raised one cycle after
    // entering DONE so that the result appears N+1 edges after the pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            res_valid  <= 1'b0;
            res_tag    <= '0;
            res_cycles <= '0;
        end else if (flush) begin
            state     <= IDLE;
            remaining <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        res_tag    <= head_tag;
                        res_cycles <= cycles;
                        remaining  <= cycles;
                        state      <= (cycles == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    remaining <= remaining - MULT_WIDTH'(1);
                    if (remaining == MULT_WIDTH'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCU_QUEUED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cycles <= '0;
            perf_jobs_done   <= '0;
        end else begin
            if (flush) begin
                perf_busy_cycles <= '0;
            end else if ((state == RUN) && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (res_fire) begin
                perf_jobs_done <= perf_jobs_done + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scu_queued.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scu_queued
//  Description : Self-checking bench for scu_queued (default geometry).
//                Expected results are queued as jobs are offered and
//                compared in order at each result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scu_queued;

    localparam int MW = 32;
    localparam int TW = 4;
    localparam int FD = 4;
    localparam int SM = 18;
    localparam int CW = $clog2(FD+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          job_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic [MW-1:0] job_mults = '0;
    logic [TW-1:0] job_tag = '0;
    logic          job_ready;
    logic          res_valid;
    logic          busy;
    logic [TW-1:0] res_tag;
    logic [MW-1:0] res_cycles;
    logic [CW-1:0] fifo_count;
`ifdef SCU_QUEUED_PERF_EN
    logic [31:0]   perf_busy_cycles;
    logic [15:0]   perf_jobs_done;
`endif

    scu_queued dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_mults  (job_mults),
        .job_tag    (job_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_tag    (res_tag),
        .res_cycles (res_cycles),
        .busy       (busy),
        .fifo_count (fifo_count)
`ifdef SCU_QUEUED_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs_done   (perf_jobs_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [MW-1:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] model_cycles(input logic [MW-1:0] m);
        logic [63:0] x;
        x = ({32'b0, m} + 64'(SM - 1)) / 64'(SM);
        return x[MW-1:0];
    endfunction

    // Handshake happens on the next rising edge; compare against the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_result", 64'(res_tag), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("res_tag", 64'(res_tag), 64'(e.tag));
                check_eq("res_cycles", 64'(res_cycles), 64'(e.cycles));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds job_valid until the job is taken (job_ready seen before an edge).
    task automatic push_job(input logic [MW-1:0] m, input logic [TW-1:0] t, input bit track);
        bit acc;
        int n;
        job_mults = m;
        job_tag   = t;
        job_valid = 1'b1;
        if (track) sb.push_back({t, model_cycles(m)});
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            acc = job_ready;
            tick();
            n++;
        end
        job_valid = 1'b0;
        if (!acc) check_eq("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((busy || fifo_count != '0 || sb.size() != 0) && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) check_eq("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (!res_valid && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) check_eq("valid_timeout", 0, 1);
    endtask

    // Pushes one job into an empty, idle unit and measures the pop edge and
    // the result edge, both counted from the enqueue edge.
    task automatic measure(input logic [MW-1:0] m, input logic [TW-1:0] t, input string name);
        int n;
        int pop_e;
        int val_e;
        push_job(m, t, 1'b1);
        n = 0;
        pop_e = -1;
        val_e = -1;
        while (val_e < 0 && n < 100) begin
            tick();
            n++;
            if (pop_e < 0 && busy) pop_e = n;
            if (res_valid) val_e = n;
        end
        check_eq({name, "_pop_edge"}, 64'(pop_e), 64'd1);
        check_eq({name, "_latency"}, 64'(val_e - pop_e), 64'(model_cycles(m)) + 64'd1);
        wait_idle(100);
    endtask

    initial begin
        int hi_valid;
        int hi_busy;
        logic [MW-1:0] tbl_m [4];
        logic [MW-1:0] pat_m [4];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_res_valid", 64'(res_valid), 0);
        check_eq("rst_busy", 64'(busy), 0);
        check_eq("rst_fifo_count", 64'(fifo_count), 0);
        check_eq("rst_res_tag", 64'(res_tag), 0);
        check_eq("rst_res_cycles", 64'(res_cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("rel_job_ready", 64'(job_ready), 1);

        // 36 mults, tag 3: pop 1 edge after enqueue, result 3 edges after pop
        res_ready = 1'b1;
        measure(32'd36, 4'd3, "m36");
        // zero mults, tag 5: result the edge after pop, no RUN cycles
        measure(32'd0, 4'd5, "m0");
        // ceiling boundaries around one multiplier group and a larger count
        pat_m = '{32'd17, 32'd18, 32'd19, 32'd1000};
        for (int i = 0; i < 4; i++) begin
            measure(pat_m[i], TW'(8 + i), "pattern");
        end

        // Back-to-back with a stalled consumer: one result parked in DONE,
        // four jobs fill the queue, the fifth must wait.
        res_ready = 1'b0;
        push_job(32'd0, 4'd6, 1'b1);
        wait_valid(20);
        tbl_m = '{32'd40, 32'd0, 32'd100, 32'd18};
        for (int i = 0; i < 4; i++) begin
            push_job(tbl_m[i], TW'(i + 1), 1'b1);
        end
        check_eq("full_count", 64'(fifo_count), 4);
        check_eq("full_ready", 64'(job_ready), 0);
        job_mults = 32'd55;
        job_tag   = 4'd5;
        job_valid = 1'b1;
        sb.push_back({4'd5, model_cycles(32'd55)});
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_ready", 64'(job_ready), 0);
            check_eq("stall_count", 64'(fifo_count), 4);
        end
        res_ready = 1'b1;
        begin
            bit acc;
            int n;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 200) begin
                acc = job_ready;
                tick();
                n++;
            end
            job_valid = 1'b0;
            check_eq("fifth_accepted", 64'(acc), 1);
        end
        wait_idle(500);
        check_eq("drain_sb_empty", 64'(sb.size()), 0);

        // Maximum count, then flush mid-RUN with two jobs queued
        push_job(32'hFFFF_FFFF, 4'd7, 1'b0);
        tick();
        check_eq("max_busy", 64'(busy), 1);
        check_eq("max_res_cycles", 64'(res_cycles), 64'd238609295);
        push_job(32'd50, 4'd8, 1'b0);
        push_job(32'd60, 4'd9, 1'b0);
        check_eq("pre_flush_count", 64'(fifo_count), 2);
        tick();
        check_eq("pre_flush_valid", 64'(res_valid), 0);
        flush     = 1'b1;
        job_valid = 1'b1;
        job_tag   = 4'd10;
        job_mults = 32'd1;
        #1;
        check_eq("flush_job_ready", 64'(job_ready), 0);
        tick();
        flush     = 1'b0;
        job_valid = 1'b0;
        check_eq("flush_busy", 64'(busy), 0);
        check_eq("flush_count", 64'(fifo_count), 0);
        check_eq("flush_res_valid", 64'(res_valid), 0);
        hi_valid = 0;
        hi_busy  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (res_valid) hi_valid++;
            if (busy) hi_busy++;
        end
        check_eq("post_flush_valid_cycles", 64'(hi_valid), 0);
        check_eq("post_flush_busy_cycles", 64'(hi_busy), 0);

        // Asynchronous reset while a result waits in DONE
        res_ready = 1'b0;
        push_job(32'd20, 4'd2, 1'b0);
        wait_valid(20);
        check_eq("pre_reset_valid", 64'(res_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_res_valid", 64'(res_valid), 0);
        check_eq("arst_busy", 64'(busy), 0);
        check_eq("arst_res_tag", 64'(res_tag), 0);
        check_eq("arst_res_cycles", 64'(res_cycles), 0);
        check_eq("arst_fifo_count", 64'(fifo_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("arst_rel_job_ready", 64'(job_ready), 1);
        check_eq("arst_rel_res_valid", 64'(res_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
